multiexp_pnt_scl_feeder: RTL and testbench



---
 rtl/multiexp_pnt_scl_feeder_pkg.sv | 18 +
 rtl/multiexp_pnt_scl_feeder_if.sv | 16 +
 rtl/multiexp_pnt_scl_feeder_ram.sv | 30 +++
 rtl/multiexp_pnt_scl_feeder.sv | 234 +++++++++++++++++++++++
 tb/tb_multiexp_pnt_scl_feeder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multiexp_pnt_scl_feeder_pkg.sv
// Shared types for the multiexp point/scalar feeder: FSM state encoding and
// default curve types used only when the instantiator does not override them.
package multiexp_pnt_scl_feeder_pkg;

  typedef enum logic [1:0] {
    LOAD,
    PRIME,
    STREAM
  } feeder_state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } fp_default_t;

  typedef logic [15:0] fe_default_t;

endpackage

// File: rtl/multiexp_pnt_scl_feeder_if.sv
// Valid/ready stream with packet delimiters, shared by the batch load port and
// the replay port toward the multiexp core.
interface if_axi_stream #(
  parameter int unsigned DAT_BITS = 8
) ();

  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic [DAT_BITS-1:0] dat;

  modport source (output val, sop, eop, dat, input rdy);
  modport sink   (input val, sop, eop, dat, output rdy);

endinterface

// File: rtl/multiexp_pnt_scl_feeder_ram.sv
// Simple dual-port batch store: one write port, one registered read port with
// single-cycle latency; no reset on the array so it maps onto block RAM.
module multiexp_pnt_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_dat,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_dat;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
    if (i_rd_en) begin
      r_rd_dat <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/multiexp_pnt_scl_feeder.sv
// Buffers one batch of {point, scalar} pairs and replays it KEY_BITS times as a
// continuous stream to the multiexp core, one pass per scalar bit.
module multiexp_pnt_scl_feeder
  import multiexp_pnt_scl_feeder_pkg::*;
#(
  parameter type         FP_TYPE  = fp_default_t,
  parameter type         FE_TYPE  = fe_default_t,
  parameter int unsigned NUM_IN   = 8,
  parameter int unsigned KEY_BITS = 256
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  if_axi_stream.sink                  i_ld_if,
  if_axi_stream.source                o_pnt_scl_if,
  output logic                        o_busy,
  output logic                        o_ld_err,
  output logic [$clog2(KEY_BITS)-1:0] o_pass
);

  localparam int unsigned DAT_BITS = $bits(FP_TYPE) + $bits(FE_TYPE);
  localparam int unsigned IDX_W    = $clog2(NUM_IN);
  localparam int unsigned PASS_W   = $clog2(KEY_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_IN - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(KEY_BITS - 1);

  feeder_state_e r_state, w_state_nxt;

  logic                w_ld_acc;
  logic                w_ld_last;
  logic                w_ld_short;
  logic                w_rd_issue;
  logic                w_pop;
  logic                w_final_pop;
  logic                w_out_free;
  logic                w_credit;
  logic [1:0]          w_occ;
  logic [DAT_BITS-1:0] w_ram_dat;
  logic                w_unused;

  logic                r_ld_rdy;
  logic                r_busy;
  logic                r_ld_err;
  logic [IDX_W-1:0]    r_wr_cnt;
  logic [IDX_W-1:0]    r_rd_idx;
  logic [PASS_W-1:0]   r_rd_pass;
  logic                r_rd_done;
  logic                r_rd_vld;
  logic                r_rd_sop;
  logic                r_rd_eop;
  logic [PASS_W-1:0]   r_pass;

  logic                r_out_val;
  logic                r_out_sop;
  logic                r_out_eop;
  logic [DAT_BITS-1:0] r_out_dat;
  logic                r_skd_val;
  logic                r_skd_sop;
  logic                r_skd_eop;
  logic [DAT_BITS-1:0] r_skd_dat;

  assign w_unused = i_ld_if.sop;

  multiexp_pnt_ram #(
    .DEPTH (NUM_IN),
    .WIDTH (DAT_BITS)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_ld_acc),
    .i_wr_addr (r_wr_cnt),
    .i_wr_dat  (i_ld_if.dat),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr (r_rd_idx),
    .o_rd_dat  (w_ram_dat)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A read may be issued only if it will find a free slot (output reg or skid)
  // when it lands next cycle, counting the beat leaving this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_acc    = 1'b0;
    w_ld_last   = 1'b0;
    w_ld_short  = 1'b0;
    w_rd_issue  = 1'b0;
    w_final_pop = 1'b0;
    w_pop       = r_out_val && o_pnt_scl_if.rdy;
    w_out_free  = !r_out_val || w_pop;
    w_occ       = 2'(r_out_val) + 2'(r_skd_val) + 2'(r_rd_vld);
    w_credit    = (w_occ <= (2'd1 + 2'(w_pop)));
    case (r_state)
      LOAD: begin
        w_ld_acc = r_ld_rdy && i_ld_if.val;
        if (w_ld_acc) begin
          if (r_wr_cnt == LAST_IDX) begin
            w_ld_last   = 1'b1;
            w_state_nxt = PRIME;
          end else if (i_ld_if.eop) begin
            w_ld_short = 1'b1;
          end
        end
      end
      PRIME: begin
        w_rd_issue  = 1'b1;
        w_state_nxt = STREAM;
      end
      STREAM: begin
        w_rd_issue  = !r_rd_done && w_credit;
        w_final_pop = w_pop && r_out_eop && (r_pass == LAST_PASS);
        if (w_final_pop) begin
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_rdy <= 1'b0;
      r_busy   <= 1'b0;
      r_ld_err <= 1'b0;
      r_wr_cnt <= '0;
    end else begin
      r_ld_rdy <= (w_state_nxt == LOAD);
      r_ld_err <= w_ld_short;
      if (w_ld_acc) begin
        r_busy <= !w_ld_short;
        if (w_ld_last || w_ld_short) begin
          r_wr_cnt <= '0;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end else if (w_final_pop) begin
        r_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_idx  <= '0;
      r_rd_pass <= '0;
      r_rd_done <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_sop  <= 1'b0;
      r_rd_eop  <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_sop <= (r_rd_idx == '0);
        r_rd_eop <= (r_rd_idx == LAST_IDX);
        if (r_rd_idx == LAST_IDX) begin
          r_rd_idx <= '0;
          if (r_rd_pass == LAST_PASS) begin
            r_rd_done <= 1'b1;
          end else begin
            r_rd_pass <= r_rd_pass + 1'b1;
          end
        end else begin
          r_rd_idx <= r_rd_idx + 1'b1;
        end
      end else if (r_state == LOAD) begin
        r_rd_idx  <= '0;
        r_rd_pass <= '0;
        r_rd_done <= 1'b0;
      end
    end
  end

  // The skid always holds the older beat, so it refills the output first and
  // a landing RAM word backfills the skid in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_val <= 1'b0;
      r_out_sop <= 1'b0;
      r_out_eop <= 1'b0;
      r_out_dat <= '0;
      r_skd_val <= 1'b0;
      r_skd_sop <= 1'b0;
      r_skd_eop <= 1'b0;
      r_skd_dat <= '0;
    end else if (w_out_free) begin
      if (r_skd_val) begin
        r_out_val <= 1'b1;
        r_out_sop <= r_skd_sop;
        r_out_eop <= r_skd_eop;
        r_out_dat <= r_skd_dat;
        r_skd_val <= r_rd_vld;
        if (r_rd_vld) begin
          r_skd_sop <= r_rd_sop;
          r_skd_eop <= r_rd_eop;
          r_skd_dat <= w_ram_dat;
        end
      end else begin
        r_out_val <= r_rd_vld;
        if (r_rd_vld) begin
          r_out_sop <= r_rd_sop;
          r_out_eop <= r_rd_eop;
          r_out_dat <= w_ram_dat;
        end
      end
    end else if (r_rd_vld) begin
      r_skd_val <= 1'b1;
      r_skd_sop <= r_rd_sop;
      r_skd_eop <= r_rd_eop;
      r_skd_dat <= w_ram_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass <= '0;
    end else if (w_pop && r_out_eop) begin
      r_pass <= (r_pass == LAST_PASS) ? '0 : r_pass + 1'b1;
    end
  end

  assign i_ld_if.rdy      = r_ld_rdy;
  assign o_pnt_scl_if.val = r_out_val;
  assign o_pnt_scl_if.sop = r_out_sop;
  assign o_pnt_scl_if.eop = r_out_eop;
  assign o_pnt_scl_if.dat = r_out_dat;
  assign o_busy           = r_busy;
  assign o_ld_err         = r_ld_err;
  assign o_pass           = r_pass;

endmodule

// File: tb/tb_multiexp_pnt_scl_feeder.sv
// Scoreboard bench for the batch feeder: NUM_IN=4, KEY_BITS=3, 8-bit x/y point
// and 8-bit scalar packed into a 24-bit stream word.
module tb_multiexp_pnt_scl_feeder;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } tb_fp_t;
  typedef logic [7:0] tb_fe_t;

  localparam int unsigned DW = 24;
  localparam int unsigned NI = 4;
  localparam int unsigned KB = 3;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
    logic [1:0]    pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic       ld_err;
  logic [1:0] pass;

  if_axi_stream #(.DAT_BITS(DW)) ld_if ();
  if_axi_stream #(.DAT_BITS(DW)) ps_if ();

  multiexp_pnt_scl_feeder #(
    .FP_TYPE  (tb_fp_t),
    .FE_TYPE  (tb_fe_t),
    .NUM_IN   (NI),
    .KEY_BITS (KB)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ld_if      (ld_if),
    .o_pnt_scl_if (ps_if),
    .o_busy       (busy),
    .o_ld_err     (ld_err),
    .o_pass       (pass)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] vec [12] = '{
    24'h11_21_A0, 24'h12_22_A1, 24'h13_23_A2, 24'h14_24_A3,
    24'h35_45_B4, 24'h36_46_B5, 24'h37_47_B6, 24'h38_48_B7,
    24'h59_69_C8, 24'h5A_6A_C9, 24'h5B_6B_CA, 24'h5C_6C_CB
  };

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int unsigned last_pop_cyc = 0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Sink-side ready: always high, or roughly 30% duty when rand_rdy is set.
  initial begin
    ps_if.rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ps_if.rdy = rand_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Monitor: pops on each handshake and checks stability across stalls.
  exp_t          mon_e;
  logic          stall_q = 1'b0;
  logic          stall_sop, stall_eop;
  logic [DW-1:0] stall_dat;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_val", 32'(ps_if.val), 32'd1);
          check("hold_dat", 32'(ps_if.dat), 32'(stall_dat));
          check("hold_sop_eop", 32'({ps_if.sop, ps_if.eop}), 32'({stall_sop, stall_eop}));
        end
        if (ps_if.val && ps_if.rdy) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got dat %0h, expected no beat", ps_if.dat);
          end else begin
            mon_e = sb_q.pop_front();
            check("beat_dat", 32'(ps_if.dat), 32'(mon_e.dat));
            check("beat_sop", 32'(ps_if.sop), 32'(mon_e.sop));
            check("beat_eop", 32'(ps_if.eop), 32'(mon_e.eop));
            check("beat_pass", 32'(pass), 32'(mon_e.pass));
          end
          n_pop++;
          last_pop_cyc = cyc;
        end
        stall_q   = ps_if.val && !ps_if.rdy;
        stall_dat = ps_if.dat;
        stall_sop = ps_if.sop;
        stall_eop = ps_if.eop;
      end
    end
  end

  task automatic ld_beat(input logic [DW-1:0] d, input logic s, input logic e);
    int unsigned n = 0;
    ld_if.val = 1'b1;
    ld_if.dat = d;
    ld_if.sop = s;
    ld_if.eop = e;
    while (1) begin
      @(negedge clk);
      if (ld_if.rdy) break;
      n++;
      if (n > 500) begin
        n_vec++;
        n_err++;
        $display("FAIL ld_timeout: got rdy 0 for %0d cycles, expected rdy 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    ld_if.val = 1'b0;
    ld_if.sop = 1'b0;
    ld_if.eop = 1'b0;
  endtask

  task automatic load_batch(input int base);
    for (int k = 0; k < NI; k++) begin
      ld_beat(vec[base+k], k == 0, k == NI - 1);
    end
  endtask

  task automatic push_batch(input int base);
    exp_t e;
    for (int p = 0; p < KB; p++) begin
      for (int k = 0; k < NI; k++) begin
        e.dat  = vec[base+k];
        e.sop  = (k == 0);
        e.eop  = (k == NI - 1);
        e.pass = 2'(p);
        sb_q.push_back(e);
      end
    end
  endtask

  // Returns #1 after the edge of the final handshake, then checks idle state.
  task automatic wait_drain(input int unsigned limit);
    int unsigned n = 0;
    while (sb_q.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > limit) begin
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", sb_q.size());
        sb_q.delete();
      end
    end
    #1;
    check("idle_val", 32'(ps_if.val), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_pass", 32'(pass), 32'd0);
    check("idle_ld_rdy", 32'(ld_if.rdy), 32'd1);
  endtask

  int unsigned t_first;
  int          base;

  initial begin
    ld_if.val = 1'b0;
    ld_if.sop = 1'b0;
    ld_if.eop = 1'b0;
    ld_if.dat = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_val", 32'(ps_if.val), 32'd0);
    check("rst_dat", 32'(ps_if.dat), 32'd0);
    check("rst_ld_rdy", 32'(ld_if.rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ld_err", 32'(ld_err), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    rst_n = 1'b1;

    // Basic replay, rdy held high: latency 2, no bubbles over 12 beats
    push_batch(0);
    load_batch(0);
    check("prime_val", 32'(ps_if.val), 32'd0);
    check("load_busy", 32'(busy), 32'd1);
    check("prime_ld_rdy", 32'(ld_if.rdy), 32'd0);
    @(posedge clk);
    #1;
    check("lat1_val", 32'(ps_if.val), 32'd0);
    @(posedge clk);
    #1;
    check("lat2_val", 32'(ps_if.val), 32'd1);
    t_first = cyc;
    wait_drain(100);
    check("no_bubble_span", last_pop_cyc - t_first, 32'd11);

    // Random backpressure
    rand_rdy = 1'b1;
    push_batch(0);
    load_batch(0);
    wait_drain(600);
    rand_rdy = 1'b0;

    // Short batch then a full batch
    ld_beat(vec[4], 1'b1, 1'b0);
    ld_beat(vec[5], 1'b0, 1'b1);
    check("short_err_pulse", 32'(ld_err), 32'd1);
    check("short_stays_load", 32'(ld_if.rdy), 32'd1);
    @(posedge clk);
    #1;
    check("short_err_clear", 32'(ld_err), 32'd0);
    push_batch(4);
    load_batch(4);
    wait_drain(100);

    // Reset in the middle of pass 1
    push_batch(8);
    load_batch(8);
    base = n_pop;
    for (int n = 0; n < 100 && n_pop < base + 6; n++) @(posedge clk);
    check("pre_rst_pops", 32'(n_pop - base), 32'd6);
    #1;
    check("pre_rst_pass", 32'(pass), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_val", 32'(ps_if.val), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pass", 32'(pass), 32'd0);
    check("arst_ld_rdy", 32'(ld_if.rdy), 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_batch(0);
    load_batch(0);
    wait_drain(100);

    // Second batch offered during replay must wait for the final eop
    push_batch(0);
    push_batch(8);
    load_batch(0);
    base = n_pop;
    ld_beat(vec[8], 1'b1, 1'b0);
    check("b2b_wait_replay", 32'(n_pop - base), 32'(NI * KB));
    for (int k = 1; k < NI; k++) ld_beat(vec[8+k], 1'b0, k == NI - 1);
    wait_drain(100);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, expected end of test", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
